// File: rtl/bufferoutput_pkg.sv
// Shared resampler package: default widths and the collector/drainer
// state encodings used by bufferoutput and bufferoutput_bank.
package bufferoutput_pkg;

  localparam int DWIDTH_DEF         = 16;
  localparam int DDWIDTH_DEF        = 2 * DWIDTH_DEF;
  localparam int NR_STREAMS_DEF     = 16;
  localparam int NR_STREAMS_LOG_DEF = 4;
  localparam int FRAC_SHIFT_DEF     = 15;

  typedef enum logic {
    COL_FILL,
    COL_WAIT
  } col_state_t;

  typedef enum logic [1:0] {
    DRN_IDLE,
    DRN_LOAD,
    DRN_SEND
  } drn_state_t;

endpackage

// File: rtl/bufferoutput_bank.sv
// One ping-pong bank: NR_STREAMS x DWIDTH storage with a single write
// port and a registered read port.
module bufferoutput_bank
  import bufferoutput_pkg::*;
#(
  parameter int DWIDTH         = DWIDTH_DEF,
  parameter int NR_STREAMS     = NR_STREAMS_DEF,
  parameter int NR_STREAMS_LOG = NR_STREAMS_LOG_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [NR_STREAMS_LOG-1:0] waddr,
  input  logic [DWIDTH-1:0]         wdata,
  input  logic                      re,
  input  logic [NR_STREAMS_LOG-1:0] raddr,
  output logic [DWIDTH-1:0]         rdata
);

  logic [DWIDTH-1:0] mem [NR_STREAMS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register resets so data_out is clean while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/bufferoutput.sv
// Ping-pong output buffer: rounds/shifts filter results into samples
// and replays them per stream. SATURATE_EN selects clamp instead of wrap.
module bufferoutput
  import bufferoutput_pkg::*;
#(
  parameter int DWIDTH         = DWIDTH_DEF,
  parameter int DDWIDTH        = DDWIDTH_DEF,
  parameter int NR_STREAMS     = NR_STREAMS_DEF,
  parameter int NR_STREAMS_LOG = NR_STREAMS_LOG_DEF,
  parameter int FRAC_SHIFT     = FRAC_SHIFT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      req_in,
  input  logic                      ack_in,
  input  logic [DDWIDTH-1:0]        data_in,
  output logic                      req_out,
  input  logic                      ack_out,
  output logic [DWIDTH-1:0]         data_out,
  output logic [NR_STREAMS_LOG-1:0] stream_out
);

  localparam logic [NR_STREAMS_LOG-1:0] LAST =
    NR_STREAMS_LOG'(NR_STREAMS - 1);
  localparam logic [DDWIDTH:0] RND =
    (DDWIDTH + 1)'(1) << (FRAC_SHIFT - 1);

  col_state_t col_state, col_next;
  drn_state_t drn_state, drn_next;

  logic                      run;
  logic                      frame_done;
  logic [1:0]                full;
  logic [1:0]                full_set;
  logic [1:0]                full_clr;
  logic                      wr_bank;
  logic                      rd_bank;
  logic [NR_STREAMS_LOG-1:0] wr_idx;
  logic [NR_STREAMS_LOG-1:0] rd_idx;
  logic                      in_xfer;
  logic                      out_xfer;
  logic                      wr_last;
  logic                      rd_last;
  logic                      rd_load;

  logic signed [DDWIDTH:0]   ext;
  logic signed [DDWIDTH:0]   sum;
  logic signed [DDWIDTH:0]   shr;
  logic [DWIDTH-1:0]         conv;
  logic [DWIDTH-1:0]         rdata0;
  logic [DWIDTH-1:0]         rdata1;

  always_comb begin
    ext = {data_in[DDWIDTH-1], data_in};
    sum = ext + RND;
    shr = sum >>> FRAC_SHIFT;
  end

`ifdef SATURATE_EN
  localparam logic signed [DDWIDTH:0] SMAX =
    {{(DDWIDTH - DWIDTH + 2){1'b0}}, {(DWIDTH - 1){1'b1}}};
  localparam logic signed [DDWIDTH:0] SMIN =
    {{(DDWIDTH - DWIDTH + 2){1'b1}}, {(DWIDTH - 1){1'b0}}};

  always_comb begin
    conv = shr[DWIDTH-1:0];
    if (shr > SMAX) begin
      conv = SMAX[DWIDTH-1:0];
    end else if (shr < SMIN) begin
      conv = SMIN[DWIDTH-1:0];
    end
  end
`else
  logic unused_hi;

  assign conv      = shr[DWIDTH-1:0];
  assign unused_hi = ^shr[DDWIDTH:DWIDTH];
`endif

  assign req_in   = run && (col_state == COL_FILL);
  assign req_out  = (drn_state == DRN_SEND);
  assign rd_load  = (drn_state == DRN_LOAD);
  assign in_xfer  = req_in && ack_in;
  assign out_xfer = req_out && ack_out;
  assign wr_last  = (wr_idx == LAST);
  assign rd_last  = (rd_idx == LAST);

  // The bank just completed is the one wr_bank has already left.
  assign full_set = !frame_done ? 2'b00 :
                    (wr_bank ? 2'b01 : 2'b10);
  assign full_clr = !(out_xfer && rd_last) ? 2'b00 :
                    (rd_bank ? 2'b10 : 2'b01);

  always_comb begin
    col_next = col_state;
    unique case (col_state)
      COL_FILL: begin
        if (in_xfer && wr_last && full[~wr_bank]) begin
          col_next = COL_WAIT;
        end
      end
      COL_WAIT: begin
        if (!full[wr_bank]) begin
          col_next = COL_FILL;
        end
      end
      default: col_next = COL_FILL;
    endcase
  end

  always_comb begin
    drn_next = drn_state;
    unique case (drn_state)
      DRN_IDLE: begin
        if (full[rd_bank]) begin
          drn_next = DRN_LOAD;
        end
      end
      DRN_LOAD: drn_next = DRN_SEND;
      DRN_SEND: begin
        if (out_xfer) begin
          if (!rd_last || full[~rd_bank]) begin
            drn_next = DRN_LOAD;
          end else begin
            drn_next = DRN_IDLE;
          end
        end
      end
      default: drn_next = DRN_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_state <= COL_FILL;
      drn_state <= DRN_IDLE;
    end else begin
      col_state <= col_next;
      drn_state <= drn_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run        <= 1'b0;
      frame_done <= 1'b0;
      full       <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_idx     <= '0;
      rd_idx     <= '0;
    end else begin
      run        <= 1'b1;
      frame_done <= in_xfer && wr_last;
      full       <= (full | full_set) & ~full_clr;
      if (in_xfer) begin
        wr_idx <= wr_last ? '0 : wr_idx + 1'b1;
        if (wr_last) begin
          wr_bank <= ~wr_bank;
        end
      end
      if (out_xfer) begin
        rd_idx <= rd_last ? '0 : rd_idx + 1'b1;
        if (rd_last) begin
          rd_bank <= ~rd_bank;
        end
      end
    end
  end

  bufferoutput_bank #(
    .DWIDTH         (DWIDTH),
    .NR_STREAMS     (NR_STREAMS),
    .NR_STREAMS_LOG (NR_STREAMS_LOG)
  ) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (in_xfer && !wr_bank),
    .waddr (wr_idx),
    .wdata (conv),
    .re    (rd_load && !rd_bank),
    .raddr (rd_idx),
    .rdata (rdata0)
  );

  bufferoutput_bank #(
    .DWIDTH         (DWIDTH),
    .NR_STREAMS     (NR_STREAMS),
    .NR_STREAMS_LOG (NR_STREAMS_LOG)
  ) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (in_xfer && wr_bank),
    .waddr (wr_idx),
    .wdata (conv),
    .re    (rd_load && rd_bank),
    .raddr (rd_idx),
    .rdata (rdata1)
  );

  assign data_out   = rd_bank ? rdata1 : rdata0;
  assign stream_out = rd_idx;

endmodule

// File: tb/tb_bufferoutput.sv
// Self-checking bench for bufferoutput: queue model of the sample stream
// plus directed latency, rounding, back-pressure and reset scenarios.
`timescale 1ns/1ps
module tb_bufferoutput;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ack_in = 1'b0;
  logic        ack_out = 1'b0;
  logic [31:0] data_in = '0;
  logic        req_in;
  logic        req_out;
  logic [15:0] data_out;
  logic [3:0]  stream_out;

  int checks = 0;
  int failures = 0;

`ifdef SATURATE_EN
  localparam logic [15:0] EXP_BIG = 16'h7FFF;
  localparam logic [15:0] EXP_NEG = 16'h8000;
`else
  localparam logic [15:0] EXP_BIG = 16'hFFFE;
  localparam logic [15:0] EXP_NEG = 16'h0000;
`endif

  typedef struct {
    logic [15:0] d;
    logic [3:0]  s;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] out_d[$];
  logic [3:0]  out_s[$];
  int          in_stream = 0;
  int          n_in = 0;
  int          n_out = 0;
  int          cyc = 0;
  int          last_in_cyc = 0;
  int          rise_cyc = -1;
  logic        prev_hold = 1'b0;
  logic        prev_req_out = 1'b0;
  logic [15:0] prev_d = '0;
  logic [3:0]  prev_s = '0;

  always #5 clk = ~clk;

  bufferoutput dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .ack_in     (ack_in),
    .data_in    (data_in),
    .req_out    (req_out),
    .ack_out    (ack_out),
    .data_out   (data_out),
    .stream_out (stream_out)
  );

  task automatic chk(input string name, input longint got,
                     input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Round half up then floor-divide by 2^15, using plain integer math.
  function automatic logic [15:0] model(input logic [31:0] d);
    longint v;
    longint q;
    v = longint'($signed(d)) + 16384;
    if (v >= 0) q = v / 32768;
    else q = -((-v + 32767) / 32768);
`ifdef SATURATE_EN
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
`endif
    return q[15:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      in_stream = 0;
      chk("rst_req_in", req_in, 0);
      chk("rst_req_out", req_out, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_stream_out", stream_out, 0);
    end else begin
      if (prev_hold) begin
        chk("hold_req_out", req_out, 1);
        chk("hold_data", data_out, prev_d);
        chk("hold_stream", stream_out, prev_s);
      end
      if (req_out && !prev_req_out && rise_cyc < 0) rise_cyc = cyc;
      if (req_out && ack_out) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", exp_q.size(), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", data_out, e.d);
          chk("out_stream", stream_out, e.s);
        end
        out_d.push_back(data_out);
        out_s.push_back(stream_out);
        n_out++;
      end
      if (req_in && ack_in) begin
        exp_q.push_back('{d: model(data_in), s: 4'(in_stream)});
        in_stream = (in_stream + 1) % 16;
        n_in++;
        last_in_cyc = cyc + 1;
      end
    end
    prev_hold    = req_out && !ack_out && !rst;
    prev_req_out = req_out;
    prev_d       = data_out;
    prev_s       = stream_out;
  end

  task automatic send(input logic [31:0] d);
    int n = 0;
    data_in = d;
    ack_in  = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_in && n < 200);
    chk("send_req_in", req_in, 1);
    @(posedge clk);
    #1;
    ack_in = 1'b0;
  endtask

  task automatic ack_one();
    int n = 0;
    while (!req_out && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ack_wait_req_out", req_out, 1);
    ack_out = 1'b1;
    @(posedge clk);
    #1;
    ack_out = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("req_in_before_first_edge", req_in, 0);
    @(negedge clk);
    chk("req_in_after_first_edge", req_in, 1);
    @(posedge clk);
    #1;

    // Frame of k*2^15, free-running downstream
    ack_out  = 1'b1;
    rise_cyc = -1;
    base     = n_out;
    for (int k = 0; k < 16; k++) send(32'(k) * 32'd32768);
    n = 0;
    while (rise_cyc < 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("first_req_out_latency", rise_cyc - last_in_cyc, 3);
    @(posedge clk);
    #1;
    drain();
    chk("f1_count", n_out - base, 16);
    chk("f1_first_data", out_d[base], 0);
    chk("f1_last_data", out_d[base + 15], 15);
    chk("f1_first_stream", out_s[base], 0);
    chk("f1_last_stream", out_s[base + 15], 15);

    // Rounding and overflow corners
    base = n_out;
    send(32'h0000_4000);
    send(32'h0000_3FFF);
    send(32'h7FFF_0000);
    send(32'h8000_0000);
    for (int k = 0; k < 12; k++) send(32'hFFFF_8000);
    drain();
    chk("round_half_up", out_d[base], 1);
    chk("round_below_half", out_d[base + 1], 0);
    chk("big_positive", out_d[base + 2], EXP_BIG);
    chk("most_negative", out_d[base + 3], EXP_NEG);
    chk("minus_one", out_d[base + 4], 16'hFFFF);

    // Downstream stalled: both banks fill, collector waits
    ack_out = 1'b0;
    for (int k = 0; k < 32; k++) send(32'(k + 3) * 32'd32768);
    @(negedge clk);
    chk("wait_req_in", req_in, 0);
    chk("wait_req_out", req_out, 1);
    chk("wait_stream_out", stream_out, 0);
    @(posedge clk);
    #1;
    ack_one();
    @(negedge clk);
    chk("one_ack_req_in", req_in, 0);
    chk("one_ack_stream_out", stream_out, 1);
    @(posedge clk);
    #1;
    repeat (14) ack_one();
    @(negedge clk);
    chk("fifteen_acks_req_in", req_in, 0);
    @(posedge clk);
    #1;
    ack_one();
    @(negedge clk);
    chk("bank_freed_req_in_low", req_in, 0);
    @(negedge clk);
    chk("bank_freed_req_in_high", req_in, 1);
    @(posedge clk);
    #1;
    ack_out = 1'b1;
    drain();

    // Reset in the middle of a frame
    for (int k = 0; k < 9; k++) send(32'(k + 50) * 32'd32768);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base = n_out;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_req_out", req_out, 0);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) send(32'(k + 200) * 32'd32768);
    drain();
    chk("post_rst_count", n_out - base, 16);
    chk("post_rst_first_stream", out_s[base], 0);
    chk("post_rst_first_data", out_d[base], 200);
    chk("post_rst_last_stream", out_s[base + 15], 15);

    // Random handshakes on both sides, 10 frames
    base = n_out;
    fork
      begin
        for (int i = 0; i < 160; i++) begin
          logic got;
          int   g;
          data_in = $urandom;
          g = 0;
          do begin
            ack_in = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            got = req_in && ack_in;
            @(posedge clk);
            #1;
            g++;
          end while (!got && g < 300);
          if (!got) chk("rand_in_stall", got, 1);
        end
        ack_in = 1'b0;
      end
      begin
        int g = 0;
        while (n_out - base < 160 && g < 20000) begin
          ack_out = ($urandom_range(0, 1) != 0);
          @(posedge clk);
          #1;
          g++;
        end
        ack_out = 1'b0;
      end
    join
    chk("rand_count", n_out - base, 160);
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
